mercury_ddio_in_capture_ctrl: RTL

Capture controller that sequences a Mercury DDIO input atom and turns its per-cycle bit pairs (high-phase bit, low-phase bit) into framed parallel words. Drives the atom's clock enable, hunts for a sync word, then assembles data words into a 2-entry output buffer with a valid/ready handshake. Sits between the pad-side DDIO input atom and the core-side receive datapath.

---
 rtl/mercury_ddio_in_capture_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mercury_ddio_in_capture_ctrl.sv
// Mercury DDIO input capture controller: drives the atom clock enable, hunts for SYNC_WORD,
// then frames bit pairs into words behind a 2-entry FIFO. MERCURY_DDIO_CAPTURE_OVFCNT_EN adds ovf_count.
module mercury_ddio_in_capture_ctrl #(
    parameter int                      WORD_PAIRS = 4,
    parameter logic [2*WORD_PAIRS-1:0] SYNC_WORD  = 8'h5A
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    ddio_h,
    input  logic                    ddio_l,
    output logic                    clkena,
    output logic [2*WORD_PAIRS-1:0] word_data,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    locked,
    output logic                    overrun
`ifdef MERCURY_DDIO_CAPTURE_OVFCNT_EN
    ,
    output logic [7:0]              ovf_count
`endif
);
    localparam int W  = 2 * WORD_PAIRS;
    localparam int FW = $clog2(WORD_PAIRS + 1);
    localparam int CW = $clog2(WORD_PAIRS);
    localparam logic [FW-1:0] FILL_FULL = FW'(WORD_PAIRS);
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);
    localparam logic [CW-1:0] PAIR_LAST = CW'(WORD_PAIRS - 1);
    localparam logic [CW-1:0] PAIR_ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_CAPTURE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_clkena_p1;
    logic [W-3:0]   r_sr;
    logic [FW-1:0]  r_fill;
    logic [CW-1:0]  r_pair_cnt;
    logic [W-1:0]   r_buf [2];
    logic [1:0]     r_count;
    logic           r_overrun;

    logic           w_pair_vld;
    logic           w_sync_hit;
    logic           w_word_done;
    logic           w_pop;
    logic           w_drop;
    logic [W-1:0]   w_sr_next;
    logic [FW-1:0]  w_fill_next;

    function automatic logic [FW-1:0] fill_sat_inc(input logic [FW-1:0] f);
        return (f == FILL_FULL) ? f : f + FILL_ONE;
    endfunction

    // The atom registers data one cycle after clkena rises, so validity lags clkena.
    assign w_pair_vld  = r_clkena_p1 && (r_state != S_IDLE);
    assign w_sr_next   = {r_sr, ddio_h, ddio_l};
    assign w_fill_next = fill_sat_inc(r_fill);
    assign w_sync_hit  = w_pair_vld && (r_state == S_HUNT) &&
                         (w_fill_next == FILL_FULL) && (w_sr_next == SYNC_WORD);
    assign w_word_done = enable && w_pair_vld && (r_state == S_CAPTURE) &&
                         (r_pair_cnt == PAIR_LAST);
    assign word_valid  = (r_count != 2'd0);
    assign word_data   = r_buf[0];
    assign overrun     = r_overrun;
    assign w_pop       = word_valid && word_ready;
    assign w_drop      = w_word_done && !w_pop && (r_count == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        clkena       = 1'b0;
        locked       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_next = S_HUNT;
            end
            S_HUNT: begin
                clkena = 1'b1;
                if (!enable)        w_state_next = S_IDLE;
                else if (w_sync_hit) w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                clkena = 1'b1;
                locked = 1'b1;
                if (!enable) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Framing: a dropped enable discards the partial word along with the hunt history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clkena_p1 <= 1'b0;
            r_sr        <= '0;
            r_fill      <= '0;
            r_pair_cnt  <= '0;
        end else begin
            r_clkena_p1 <= clkena;
            if ((r_state == S_IDLE) || !enable) begin
                r_sr       <= '0;
                r_fill     <= '0;
                r_pair_cnt <= '0;
            end else if (w_pair_vld) begin
                r_sr <= w_sr_next[W-3:0];
                if (r_state == S_HUNT) begin
                    r_fill     <= w_fill_next;
                    r_pair_cnt <= '0;
                end else begin
                    r_pair_cnt <= (r_pair_cnt == PAIR_LAST) ? '0 : r_pair_cnt + PAIR_ONE;
                end
            end
        end
    end

    // Output FIFO: a simultaneous pop frees the slot a full-buffer push needs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
            r_count   <= 2'd0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            case ({w_word_done, w_pop})
                2'b01: begin
                    r_buf[0] <= r_buf[1];
                    r_count  <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf[0] <= w_sr_next;
                        r_count  <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_buf[1] <= w_sr_next;
                        r_count  <= 2'd2;
                    end
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf[0] <= w_sr_next;
                    end else begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= w_sr_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MERCURY_DDIO_CAPTURE_OVFCNT_EN
    logic [7:0] r_ovf_count;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)       r_ovf_count <= 8'd0;
        else if (w_drop) r_ovf_count <= sat_inc8(r_ovf_count);
    end

    assign ovf_count = r_ovf_count;
`endif

endmodule
